instr_sequencer: RTL and testbench

- Parametrised instruction-sequencing controller that fetches from an instruction ROM through `pc`, decodes opcode/operands and drives a datapath with an enable/done handshake.
- Adds configurable operand/opcode width and ROM read latency, a jump opcode, a done-timeout watchdog, abort, sticky error status and a retired-instruction counter.
- Sits between the instruction memory and the ALU/datapath.

---
 rtl/instr_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//   Instruction-sequencing controller. Fetches {opcode, a, b} words from an
//   instruction ROM addressed by pc, decodes them and drives a datapath through
//   an enable/done handshake. Supports jump and halt opcodes, a done-timeout
//   watchdog, abort, sticky error flags and a saturating retired-op counter.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   go             start pulse, accepted in IDLE or ERROR
//   abort          synchronous return to IDLE from any non-IDLE state
//   instruction    ROM data for the current pc
//   done           datapath completion, only looked at in EXEC
//   enable         datapath enable, high in every EXEC cycle
//   pc             ROM address
//   opcode, a, b   latched instruction fields
//   busy           high in FETCH, DECODE and EXEC
//   halted         program ended by the halt opcode
//   invalid_opcode sticky undefined-opcode flag
//   timeout_err    sticky watchdog flag
//   instr_count    retired datapath instructions, saturating
// -----------------------------------------------------------------------------
module instr_sequencer #(
  parameter int OPERAND_W     = 8,
  parameter int OPC_W         = 4,
  parameter int ADDR          = 5,
  parameter int INSTR_LEN     = OPC_W + 2 * OPERAND_W,
  parameter int NUM_VALID_OPS = 4,
  parameter int JUMP_OPC      = (1 << OPC_W) - 2,
  parameter int HALT_OPC      = (1 << OPC_W) - 1,
  parameter int MEM_LAT       = 1,
  parameter int TIMEOUT       = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  input  logic                 abort,
  input  logic [INSTR_LEN-1:0] instruction,
  input  logic                 done,
  output logic                 enable,
  output logic [ADDR-1:0]      pc,
  output logic [OPC_W-1:0]     opcode,
  output logic [OPERAND_W-1:0] a,
  output logic [OPERAND_W-1:0] b,
  output logic                 busy,
  output logic                 halted,
  output logic                 invalid_opcode,
  output logic                 timeout_err,
  output logic [ADDR:0]        instr_count
);

  localparam int LAT_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Watchdog fires in the TIMEOUT-th EXEC cycle, when the counter holds TIMEOUT-1.
  localparam int WD_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [ADDR-1:0]      pc_r, pc_nxt_s;
  logic [OPC_W-1:0]     opcode_r, opcode_nxt_s;
  logic [OPERAND_W-1:0] a_r, a_nxt_s;
  logic [OPERAND_W-1:0] b_r, b_nxt_s;
  logic                 enable_r, enable_nxt_s;
  logic                 busy_r, busy_nxt_s;
  logic                 halted_r, halted_nxt_s;
  logic                 inv_r, inv_nxt_s;
  logic                 to_r, to_nxt_s;
  logic [ADDR:0]        cnt_r, cnt_nxt_s;
  logic [LAT_W-1:0]     lat_r, lat_nxt_s;
  logic [WD_W-1:0]      wd_r, wd_nxt_s;

  // Next-state and next-output logic; abort overrides everything outside IDLE.
  always_comb begin
    state_nxt_s  = state_r;
    pc_nxt_s     = pc_r;
    opcode_nxt_s = opcode_r;
    a_nxt_s      = a_r;
    b_nxt_s      = b_r;
    halted_nxt_s = halted_r;
    inv_nxt_s    = inv_r;
    to_nxt_s     = to_r;
    cnt_nxt_s    = cnt_r;
    lat_nxt_s    = lat_r;
    wd_nxt_s     = wd_r;
    if (abort && (state_r != ST_IDLE)) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (go) begin
            state_nxt_s  = ST_FETCH;
            pc_nxt_s     = '0;
            cnt_nxt_s    = '0;
            halted_nxt_s = 1'b0;
            lat_nxt_s    = '0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_ERROR: begin
          if (go) begin
            state_nxt_s  = ST_FETCH;
            pc_nxt_s     = '0;
            cnt_nxt_s    = '0;
            halted_nxt_s = 1'b0;
            lat_nxt_s    = '0;
            inv_nxt_s    = 1'b0;
            to_nxt_s     = 1'b0;
          end else begin
            state_nxt_s = ST_ERROR;
          end
        end
        ST_FETCH: begin
          // pc is held for MEM_LAT cycles; fields are captured on the last one.
          if (lat_r == LAT_W'(MEM_LAT - 1)) begin
            opcode_nxt_s = instruction[INSTR_LEN-1 -: OPC_W];
            a_nxt_s      = instruction[2*OPERAND_W-1 -: OPERAND_W];
            b_nxt_s      = instruction[OPERAND_W-1:0];
            lat_nxt_s    = '0;
            state_nxt_s  = ST_DECODE;
          end else begin
            lat_nxt_s = lat_r + LAT_W'(1);
          end
        end
        ST_DECODE: begin
          // Halt and jump are checked before the datapath-range test.
          if (opcode_r == OPC_W'(HALT_OPC)) begin
            halted_nxt_s = 1'b1;
            state_nxt_s  = ST_IDLE;
          end else if (opcode_r == OPC_W'(JUMP_OPC)) begin
            pc_nxt_s    = ADDR'(a_r);
            lat_nxt_s   = '0;
            state_nxt_s = ST_FETCH;
          end else if ({1'b0, opcode_r} < (OPC_W + 1)'(NUM_VALID_OPS)) begin
            wd_nxt_s    = '0;
            state_nxt_s = ST_EXEC;
          end else begin
            inv_nxt_s   = 1'b1;
            state_nxt_s = ST_ERROR;
          end
        end
        ST_EXEC: begin
          // done beats a watchdog expiry landing in the same cycle.
          if (done) begin
            pc_nxt_s    = pc_r + ADDR'(1);
            cnt_nxt_s   = (cnt_r == {(ADDR + 1){1'b1}}) ? cnt_r : cnt_r + (ADDR + 1)'(1);
            lat_nxt_s   = '0;
            state_nxt_s = ST_FETCH;
          end else if ((TIMEOUT > 0) && (wd_r == WD_W'(WD_LAST))) begin
            to_nxt_s    = 1'b1;
            state_nxt_s = ST_ERROR;
          end else begin
            wd_nxt_s = wd_r + WD_W'(1);
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
    // enable/busy are registered from the upcoming state so they align with it.
    enable_nxt_s = (state_nxt_s == ST_EXEC);
    busy_nxt_s   = (state_nxt_s == ST_FETCH) || (state_nxt_s == ST_DECODE) ||
                   (state_nxt_s == ST_EXEC);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      pc_r     <= '0;
      opcode_r <= '0;
      a_r      <= '0;
      b_r      <= '0;
      enable_r <= 1'b0;
      busy_r   <= 1'b0;
      halted_r <= 1'b0;
      inv_r    <= 1'b0;
      to_r     <= 1'b0;
      cnt_r    <= '0;
      lat_r    <= '0;
      wd_r     <= '0;
    end else begin
      state_r  <= state_nxt_s;
      pc_r     <= pc_nxt_s;
      opcode_r <= opcode_nxt_s;
      a_r      <= a_nxt_s;
      b_r      <= b_nxt_s;
      enable_r <= enable_nxt_s;
      busy_r   <= busy_nxt_s;
      halted_r <= halted_nxt_s;
      inv_r    <= inv_nxt_s;
      to_r     <= to_nxt_s;
      cnt_r    <= cnt_nxt_s;
      lat_r    <= lat_nxt_s;
      wd_r     <= wd_nxt_s;
    end
  end

  assign enable         = enable_r;
  assign pc             = pc_r;
  assign opcode         = opcode_r;
  assign a              = a_r;
  assign b              = b_r;
  assign busy           = busy_r;
  assign halted         = halted_r;
  assign invalid_opcode = inv_r;
  assign timeout_err    = to_r;
  assign instr_count    = cnt_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
//   Directed bench for instr_sequencer. dut_a uses default widths with a
//   10-cycle watchdog; dut_b uses ADDR=2 and a 3-cycle ROM latency.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // dut_a: default widths, TIMEOUT=10
  logic        go_a, abort_a, done_a;
  logic [19:0] instr_a;
  logic        en_a, busy_a, halted_a, inv_a, to_a;
  logic [4:0]  pc_a;
  logic [3:0]  opc_a;
  logic [7:0]  a_a, b_a;
  logic [5:0]  cnt_a;
  logic [19:0] rom_a [32];
  assign instr_a = rom_a[pc_a];

  instr_sequencer #(.TIMEOUT(10)) dut_a (
    .clk(clk), .reset(rst_n), .go(go_a), .abort(abort_a), .instruction(instr_a),
    .done(done_a), .enable(en_a), .pc(pc_a), .opcode(opc_a), .a(a_a), .b(b_a),
    .busy(busy_a), .halted(halted_a), .invalid_opcode(inv_a), .timeout_err(to_a),
    .instr_count(cnt_a)
  );

  // dut_b: ADDR=2, MEM_LAT=3
  logic        go_b, abort_b, done_b;
  logic [19:0] instr_b;
  logic        en_b, busy_b, halted_b, inv_b, to_b;
  logic [1:0]  pc_b;
  logic [3:0]  opc_b;
  logic [7:0]  a_b, b_b;
  logic [2:0]  cnt_b;
  logic [19:0] rom_b [4];
  assign instr_b = rom_b[pc_b];

  instr_sequencer #(.ADDR(2), .MEM_LAT(3)) dut_b (
    .clk(clk), .reset(rst_n), .go(go_b), .abort(abort_b), .instruction(instr_b),
    .done(done_b), .enable(en_b), .pc(pc_b), .opcode(opc_b), .a(a_b), .b(b_b),
    .busy(busy_b), .halted(halted_b), .invalid_opcode(inv_b), .timeout_err(to_b),
    .instr_count(cnt_b)
  );

  // Traces collected by run_a
  logic [4:0] pc_seq [$];
  int         run_len [$];
  logic [7:0] ea_q [$];
  logic [7:0] eb_q [$];
  int         en_total;

  function automatic string pc_str();
    string s = "";
    foreach (pc_seq[i]) s = {s, $sformatf("%0d ", pc_seq[i])};
    return s;
  endfunction

  function automatic string run_str();
    string s = "";
    foreach (run_len[i]) s = {s, $sformatf("%0d ", run_len[i])};
    return s;
  endfunction

  task automatic clear_rom_a();
    for (int i = 0; i < 32; i++) rom_a[i] = 20'h0;
  endtask

  // Pulse go on dut_a and act as datapath: done rises in the done_dly-th
  // enable cycle (0 = never). Runs until busy drops or max_cyc expires.
  task automatic run_a(input int done_dly, input int max_cyc);
    int run;
    run = 0;
    en_total = 0;
    pc_seq.delete(); run_len.delete(); ea_q.delete(); eb_q.delete();
    @(negedge clk); go_a = 1'b1;
    @(negedge clk); go_a = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (busy_a && ((pc_seq.size() == 0) || (pc_seq[$] != pc_a))) pc_seq.push_back(pc_a);
      if (en_a) begin
        run++;
        en_total++;
        if (run == 1) begin
          ea_q.push_back(a_a);
          eb_q.push_back(b_a);
        end
        done_a = (done_dly > 0) && (run >= done_dly);
      end else begin
        if (run > 0) run_len.push_back(run);
        run = 0;
        done_a = 1'b0;
      end
      if (!busy_a) break;
      @(negedge clk);
    end
    done_a = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    n_vec++;
    if ({en_a, busy_a, halted_a, inv_a, to_a} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags_a: got %b expected 00000", {en_a, busy_a, halted_a, inv_a, to_a});
    end
    n_vec++;
    if ({pc_a, opc_a, a_a, b_a, cnt_a} !== 31'd0) begin
      n_err++; $display("FAIL reset_data_a: got %h expected 0", {pc_a, opc_a, a_a, b_a, cnt_a});
    end
    n_vec++;
    if ({en_b, busy_b, halted_b, inv_b, to_b, pc_b, opc_b, a_b, b_b, cnt_b} !== 32'd0) begin
      n_err++; $display("FAIL reset_all_b: got %h expected 0",
                        {en_b, busy_b, halted_b, inv_b, to_b, pc_b, opc_b, a_b, b_b, cnt_b});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({busy_a, en_a} !== 2'b00) begin
      n_err++; $display("FAIL reset_release_idle: got %b expected 00", {busy_a, en_a});
    end
  endtask

  task automatic test_program();
    clear_rom_a();
    rom_a[0] = {4'h0, 8'h12, 8'h34};
    rom_a[1] = {4'h1, 8'h05, 8'h06};
    rom_a[2] = {4'hF, 8'h00, 8'h00};
    run_a(2, 60);
    n_vec++;
    if (pc_seq.size() != 3 || pc_seq[0] !== 5'd0 || pc_seq[1] !== 5'd1 || pc_seq[2] !== 5'd2) begin
      n_err++; $display("FAIL prog_pc_seq: got %s expected 0 1 2", pc_str());
    end
    n_vec++;
    if (run_len.size() != 2 || run_len[0] != 2 || run_len[1] != 2) begin
      n_err++; $display("FAIL prog_enable_len: got %s expected 2 2", run_str());
    end
    n_vec++;
    if (ea_q.size() != 2 || ea_q[0] !== 8'h12 || eb_q[0] !== 8'h34 || ea_q[1] !== 8'h05 || eb_q[1] !== 8'h06) begin
      n_err++; $display("FAIL prog_operands: got %0d ops, first a=%h b=%h expected 2 ops 12/34 05/06",
                        ea_q.size(), a_a, b_a);
    end
    n_vec++;
    if ({halted_a, busy_a, en_a, cnt_a} !== {1'b1, 1'b0, 1'b0, 6'd2}) begin
      n_err++; $display("FAIL prog_end_status: got halted=%b busy=%b en=%b cnt=%0d expected 1 0 0 2",
                        halted_a, busy_a, en_a, cnt_a);
    end
  endtask

  task automatic test_jump();
    clear_rom_a();
    rom_a[0] = {4'hE, 8'h03, 8'h00};
    rom_a[3] = {4'h2, 8'hAA, 8'h55};
    rom_a[4] = {4'hF, 8'h00, 8'h00};
    run_a(1, 60);
    n_vec++;
    if (pc_seq.size() != 3 || pc_seq[0] !== 5'd0 || pc_seq[1] !== 5'd3 || pc_seq[2] !== 5'd4) begin
      n_err++; $display("FAIL jump_pc_seq: got %s expected 0 3 4", pc_str());
    end
    n_vec++;
    if (en_total != 1 || ea_q.size() != 1 || ea_q[0] !== 8'hAA) begin
      n_err++; $display("FAIL jump_enable: got %0d enable cycles expected 1 (op at pc 3)", en_total);
    end
    n_vec++;
    if ({halted_a, busy_a, cnt_a} !== {1'b1, 1'b0, 6'd1}) begin
      n_err++; $display("FAIL jump_end_status: got halted=%b busy=%b cnt=%0d expected 1 0 1",
                        halted_a, busy_a, cnt_a);
    end
  endtask

  task automatic test_invalid();
    clear_rom_a();
    rom_a[0] = {4'h5, 8'h11, 8'h22};
    run_a(1, 30);
    n_vec++;
    if ({inv_a, busy_a, halted_a, opc_a} !== {1'b1, 1'b0, 1'b0, 4'h5}) begin
      n_err++; $display("FAIL invalid_flag: got inv=%b busy=%b halted=%b opc=%h expected 1 0 0 5",
                        inv_a, busy_a, halted_a, opc_a);
    end
    n_vec++;
    if (en_total != 0) begin
      n_err++; $display("FAIL invalid_no_enable: got %0d enable cycles expected 0", en_total);
    end
    rom_a[0] = {4'hF, 8'h00, 8'h00};
    run_a(1, 30);
    n_vec++;
    if ({inv_a, halted_a, busy_a} !== 3'b010 || pc_seq.size() != 1 || pc_seq[0] !== 5'd0) begin
      n_err++; $display("FAIL invalid_restart: got inv=%b halted=%b busy=%b pcs=%s expected 0 1 0 pcs 0",
                        inv_a, halted_a, busy_a, pc_str());
    end
  endtask

  task automatic test_timeout();
    clear_rom_a();
    rom_a[0] = {4'h1, 8'h21, 8'h43};
    rom_a[1] = {4'hF, 8'h00, 8'h00};
    run_a(0, 60);
    n_vec++;
    if (run_len.size() != 1 || run_len[0] != 10) begin
      n_err++; $display("FAIL timeout_enable_len: got %s expected 10", run_str());
    end
    n_vec++;
    if ({to_a, en_a, busy_a, halted_a, pc_a, cnt_a} !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0}) begin
      n_err++; $display("FAIL timeout_error: got to=%b en=%b busy=%b halted=%b pc=%0d cnt=%0d expected 1 0 0 0 0 0",
                        to_a, en_a, busy_a, halted_a, pc_a, cnt_a);
    end
    run_a(10, 60);
    n_vec++;
    if (run_len.size() != 1 || run_len[0] != 10) begin
      n_err++; $display("FAIL timeout_edge_len: got %s expected 10", run_str());
    end
    n_vec++;
    if ({to_a, halted_a, cnt_a} !== {1'b0, 1'b1, 6'd1} || pc_seq.size() != 2 || pc_seq[1] !== 5'd1) begin
      n_err++; $display("FAIL timeout_edge_done_wins: got to=%b halted=%b cnt=%0d pcs=%s expected 0 1 1 pcs 0 1",
                        to_a, halted_a, cnt_a, pc_str());
    end
  endtask

  task automatic test_mem_latency();
    logic [1:0] exp_pc;
    logic       exp_en;
    int         ret;
    for (int k = 0; k < 4; k++) rom_b[k] = {4'h0, 8'h40 + 8'(k), 8'(k)};
    done_b = 1'b1;
    @(negedge clk); go_b = 1'b1;
    @(negedge clk); go_b = 1'b0;
    // Each op: 3 FETCH + 1 DECODE + 1 EXEC cycle; go in cycle 12 must be ignored.
    for (int i = 1; i <= 42; i++) begin
      exp_pc = 2'(((i - 1) / 5) % 4);
      exp_en = ((i % 5) == 0);
      ret    = (i - 1) / 5;
      if (ret > 7) ret = 7;
      n_vec++;
      if (pc_b !== exp_pc) begin
        n_err++; $display("FAIL memlat_pc cycle %0d: got %0d expected %0d", i, pc_b, exp_pc);
      end
      n_vec++;
      if (en_b !== exp_en) begin
        n_err++; $display("FAIL memlat_enable cycle %0d: got %b expected %b", i, en_b, exp_en);
      end
      n_vec++;
      if (cnt_b !== 3'(ret)) begin
        n_err++; $display("FAIL memlat_count cycle %0d: got %0d expected %0d", i, cnt_b, ret);
      end
      if (exp_en) begin
        n_vec++;
        if (a_b !== (8'h40 + 8'(exp_pc))) begin
          n_err++; $display("FAIL memlat_operand cycle %0d: got %h expected %h", i, a_b, 8'h40 + 8'(exp_pc));
        end
      end
      go_b = (i == 12);
      @(negedge clk);
    end
    abort_b = 1'b1;
    @(negedge clk); abort_b = 1'b0; done_b = 1'b0;
    n_vec++;
    if ({busy_b, en_b, cnt_b} !== {1'b0, 1'b0, 3'd7}) begin
      n_err++; $display("FAIL memlat_abort: got busy=%b en=%b cnt=%0d expected 0 0 7", busy_b, en_b, cnt_b);
    end
  endtask

  task automatic start_jump_prog(input string tag);
    int k;
    clear_rom_a();
    rom_a[0] = {4'hE, 8'h05, 8'h00};
    rom_a[5] = {4'h3, 8'h99, 8'h66};
    rom_a[6] = {4'hF, 8'h00, 8'h00};
    done_a = 1'b0;
    @(negedge clk); go_a = 1'b1;
    @(negedge clk); go_a = 1'b0;
    k = 0;
    while (!en_a && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if ({en_a, pc_a} !== {1'b1, 5'd5}) begin
      n_err++; $display("FAIL %s_reach_exec: got en=%b pc=%0d expected 1 5", tag, en_a, pc_a);
    end
  endtask

  task automatic test_abort();
    start_jump_prog("abort");
    @(negedge clk);
    abort_a = 1'b1;
    done_a  = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    done_a  = 1'b0;
    n_vec++;
    if ({en_a, busy_a} !== 2'b00) begin
      n_err++; $display("FAIL abort_enable_drop: got en=%b busy=%b expected 0 0", en_a, busy_a);
    end
    n_vec++;
    if ({pc_a, opc_a, a_a, b_a, cnt_a, halted_a} !== {5'd5, 4'h3, 8'h99, 8'h66, 6'd0, 1'b0}) begin
      n_err++; $display("FAIL abort_hold: got pc=%0d opc=%h a=%h b=%h cnt=%0d halted=%b expected 5 3 99 66 0 0",
                        pc_a, opc_a, a_a, b_a, cnt_a, halted_a);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy_a, en_a, pc_a} !== {1'b0, 1'b0, 5'd5}) begin
      n_err++; $display("FAIL abort_stay_idle: got busy=%b en=%b pc=%0d expected 0 0 5", busy_a, en_a, pc_a);
    end
  endtask

  task automatic test_reset_mid_exec();
    start_jump_prog("rstmid");
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({en_a, busy_a, halted_a, inv_a, to_a, pc_a, opc_a, a_a, b_a, cnt_a} !== 36'd0) begin
      n_err++; $display("FAIL rstmid_clear: got %h expected 0",
                        {en_a, busy_a, halted_a, inv_a, to_a, pc_a, opc_a, a_a, b_a, cnt_a});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({busy_a, en_a, pc_a} !== {1'b0, 1'b0, 5'd0}) begin
      n_err++; $display("FAIL rstmid_idle: got busy=%b en=%b pc=%0d expected 0 0 0", busy_a, en_a, pc_a);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    go_a    = 1'b0; abort_a = 1'b0; done_a = 1'b0;
    go_b    = 1'b0; abort_b = 1'b0; done_b = 1'b0;
    clear_rom_a();
    for (int k = 0; k < 4; k++) rom_b[k] = 20'h0;
    test_reset();
    test_program();
    test_jump();
    test_invalid();
    test_timeout();
    test_mem_latency();
    test_abort();
    test_reset_mid_exec();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
